// File: rtl/hd6309_trace_uart.sv
// rtl/hd6309_trace_uart.sv - HD6309 trace word FIFO with 8N1 UART serialiser and drop counter
// Define TRACE_UART_SYNC_EN to prefix every word with sync byte 0xA5.
module hd6309_trace_uart #(
   parameter int CLK_DIV = 434,
   parameter int FIFO_AW = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        st_valid,
   input  logic [31:0] st_data,
   input  logic        clr_ovf,
   output logic        tx,
   output logic        busy,
   output logic        overflow,
   output logic [7:0]  drop_count
);
`ifdef TRACE_UART_SYNC_EN
   localparam int BW = 3;
   localparam logic [BW-1:0] LAST_BYTE = 3'd4;
`else
   localparam int BW = 2;
   localparam logic [BW-1:0] LAST_BYTE = 2'd3;
`endif
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t state_q, state_d;
   logic [31:0] mem_q [DEPTH];
   logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [31:0] word_q, word_d;
   logic [15:0] timer_q, timer_d;
   logic [2:0] bit_q, bit_d;
   logic [BW-1:0] byte_q, byte_d;
   logic tx_q, tx_d;
   logic ovf_q, ovf_d;
   logic [7:0] drop_q, drop_d;
   logic empty, full, pop, wr_en, drop, tick, shift_ok;
   logic [7:0] cur_byte;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                  (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   assign pop   = (state_q == IDLE) && !empty;
   // A pop in the same cycle frees a slot, so a write while full is still accepted.
   assign wr_en = st_valid && (!full || pop);
   assign drop  = st_valid && full && !pop;
   assign tick  = (timer_q == DIV_M1);

`ifdef TRACE_UART_SYNC_EN
   assign cur_byte = (byte_q == '0) ? 8'hA5 : word_q[31:24];
   assign shift_ok = (byte_q != '0);
`else
   assign cur_byte = word_q[31:24];
   assign shift_ok = 1'b1;
`endif

   assign tx         = tx_q;
   assign busy       = !empty || (state_q != IDLE);
   assign overflow   = ovf_q;
   assign drop_count = drop_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_comb begin
      ovf_d  = ovf_q;
      drop_d = drop_q;
      if (drop) begin
         ovf_d = 1'b1;
         if (clr_ovf)               drop_d = 8'd1;
         else if (drop_q != 8'hFF)  drop_d = drop_q + 8'd1;
      end else if (clr_ovf) begin
         ovf_d  = 1'b0;
         drop_d = 8'd0;
      end
   end

   // tx is registered from the current state, so the line lags the FSM by one cycle.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      timer_d = timer_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      tx_d    = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (pop) begin
               word_d  = mem_q[rd_ptr_q[FIFO_AW-1:0]];
               byte_d  = '0;
               timer_d = '0;
               state_d = START;
            end
         end
         START: begin
            tx_d = 1'b0;
            if (tick) begin
               timer_d = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         DATA: begin
            tx_d = cur_byte[bit_q];
            if (tick) begin
               timer_d = '0;
               if (bit_q == 3'd7) state_d = STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         STOP: begin
            if (tick) begin
               timer_d = '0;
               if (byte_q == LAST_BYTE) begin
                  state_d = IDLE;
               end else begin
                  byte_d  = byte_q + BW'(1);
                  if (shift_ok) word_d = {word_q[23:0], 8'h00};
                  state_d = START;
               end
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= st_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         word_q   <= '0;
         timer_q  <= '0;
         bit_q    <= '0;
         byte_q   <= '0;
         tx_q     <= 1'b1;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         word_q   <= word_d;
         timer_q  <= timer_d;
         bit_q    <= bit_d;
         byte_q   <= byte_d;
         tx_q     <= tx_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end
endmodule

// File: tb/tb_hd6309_trace_uart.sv
// tb/tb_hd6309_trace_uart.sv - scoreboard bench for hd6309_trace_uart (CLK_DIV=4, FIFO_AW=2)
module tb_hd6309_trace_uart;
   localparam int CLK_DIV = 4;
`ifdef TRACE_UART_SYNC_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif
   localparam int WORD_CYC = NB * 10 * CLK_DIV + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic st_valid = 1'b0;
   logic [31:0] st_data = '0;
   logic clr_ovf = 1'b0;
   logic tx, busy, overflow;
   logic [7:0] drop_count;

   int n_assert = 0;
   int n_fail = 0;
   logic [7:0] exp_q[$];
   int starts[$];
   int cyc = 0;
   bit mon_en = 1'b0;
   bit dec_active = 1'b0;
   int dec_cnt = 0;
   logic [7:0] dec_byte = '0;
   logic prev_tx = 1'b1;

   hd6309_trace_uart #(.CLK_DIV(CLK_DIV), .FIFO_AW(2)) dut (
      .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_data(st_data),
      .clr_ovf(clr_ovf), .tx(tx), .busy(busy), .overflow(overflow),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] w);
`ifdef TRACE_UART_SYNC_EN
      exp_q.push_back(8'hA5);
`endif
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int limit);
      int i = 0;
      while ((exp_q.size() != 0 || dec_active) && i < limit) begin
         @(posedge clk);
         i++;
      end
      #1;
      check("drain_in_time", 32'(i < limit), 32'd1);
   endtask

   // UART receiver: samples mid-bit on the falling clock edge.
   always @(negedge clk) begin
      if (!mon_en) begin
         dec_active = 1'b0;
         prev_tx = 1'b1;
      end else if (!dec_active) begin
         if (prev_tx === 1'b1 && tx === 1'b0) begin
            dec_active = 1'b1;
            dec_cnt = 0;
            starts.push_back(cyc);
         end
         prev_tx = tx;
      end else begin
         dec_cnt++;
         for (int i = 0; i < 8; i++)
            if (dec_cnt == CLK_DIV * (i + 1) + CLK_DIV / 2) dec_byte[i] = tx;
         if (dec_cnt == 9 * CLK_DIV + CLK_DIV / 2) begin
            check("stop_bit", {31'h0, tx}, 32'd1);
            if (exp_q.size() == 0) check("rx_extra_byte", 32'(exp_q.size()), 32'd1);
            else check("rx_byte", {24'h0, dec_byte}, {24'h0, exp_q.pop_front()});
            dec_active = 1'b0;
            prev_tx = tx;
         end
      end
   end

   initial begin
      logic [31:0] words [6];
      int cycles;
      bit bad;
      words[0] = 32'hA1B2C340; words[1] = 32'h00FF5A80; words[2] = 32'hFFFE01C0;
      words[3] = 32'h7E8100C0; words[4] = 32'h13572440; words[5] = 32'hDEADBE00;

      tick(3);
      rst_n = 1'b1;
      check("rst_tx", {31'h0, tx}, 32'd1);
      check("rst_busy", {31'h0, busy}, 32'd0);
      check("rst_ovf", {31'h0, overflow}, 32'd0);
      check("rst_drop", {24'h0, drop_count}, 32'd0);
      bad = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick(1);
         if (tx !== 1'b1 || busy !== 1'b0 || drop_count !== 8'd0) bad = 1'b1;
      end
      check("idle_1000", {31'h0, bad}, 32'd0);
      mon_en = 1'b1;

      st_valid = 1'b1;
      st_data = 32'h1234_5600;
      push_word(32'h1234_5600);
      tick(1);
      st_valid = 1'b0;
      check("busy_after_write", {31'h0, busy}, 32'd1);
      tick(1);
      check("tx_high_n1", {31'h0, tx}, 32'd1);
      tick(1);
      check("tx_low_n2", {31'h0, tx}, 32'd0);
      cycles = 2;
      while (busy && cycles < 1000) begin
         tick(1);
         cycles++;
      end
      check("busy_fall_cycles", 32'(cycles), 32'(WORD_CYC));
      wait_drain(300);

      starts.delete();
      for (int i = 0; i < 6; i++) begin
         st_valid = 1'b1;
         st_data = words[i];
         if (i < 5) push_word(words[i]);
         tick(1);
      end
      st_valid = 1'b0;
      check("burst_ovf", {31'h0, overflow}, 32'd1);
      check("burst_drop", {24'h0, drop_count}, 32'd1);
      wait_drain(6 * WORD_CYC + 100);
      check("burst_nbytes", 32'(starts.size()), 32'(5 * NB));
      if (starts.size() == 5 * NB) begin
         check("byte_spacing", 32'(starts[1] - starts[0]), 32'(10 * CLK_DIV));
         check("word_spacing", 32'(starts[NB] - starts[0]), 32'(WORD_CYC));
         check("word4_spacing", 32'(starts[4 * NB] - starts[0]), 32'(4 * WORD_CYC));
      end

      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      check("clr_ovf", {31'h0, overflow}, 32'd0);
      check("clr_drop", {24'h0, drop_count}, 32'd0);
      tick(10);

      // Fill the FIFO, then strobe exactly on the edge where the next pop happens.
      for (int i = 0; i < 5; i++) begin
         st_valid = 1'b1;
         st_data = words[i] ^ 32'h5555_5500;
         push_word(words[i] ^ 32'h5555_5500);
         tick(1);
      end
      st_valid = 1'b0;
      tick(157);
      st_valid = 1'b1;
      st_data = 32'hC0DE_4200;
      push_word(32'hC0DE_4200);
      tick(1);
      st_valid = 1'b0;
      check("fullpop_drop", {24'h0, drop_count}, 32'd0);
      check("fullpop_ovf", {31'h0, overflow}, 32'd0);
      wait_drain(6 * WORD_CYC + 100);
      tick(10);

      mon_en = 1'b0;
      for (int i = 0; i < 320; i++) begin
         st_valid = 1'b1;
         st_data = 32'h0BAD_0000;
         tick(1);
      end
      check("sat_drop", {24'h0, drop_count}, 32'd255);
      check("sat_ovf", {31'h0, overflow}, 32'd1);
      st_valid = 1'b0;
      clr_ovf = 1'b1;
      tick(1);
      check("sat_clr_drop", {24'h0, drop_count}, 32'd0);
      check("sat_clr_ovf", {31'h0, overflow}, 32'd0);
      st_valid = 1'b1;
      tick(1);
      st_valid = 1'b0;
      clr_ovf = 1'b0;
      check("clr_vs_drop_cnt", {24'h0, drop_count}, 32'd1);
      check("clr_vs_drop_ovf", {31'h0, overflow}, 32'd1);
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      check("flush_busy", {31'h0, busy}, 32'd0);
      check("flush_drop", {24'h0, drop_count}, 32'd0);
      tick(2);

      mon_en = 1'b1;
      st_valid = 1'b1;
      st_data = 32'hFACE_0100;
      push_word(32'hFACE_0100);
      tick(1);
      st_valid = 1'b0;
      cycles = 0;
      while (tx !== 1'b0 && cycles < 20) begin
         tick(1);
         cycles++;
      end
      check("midrst_start_seen", {31'h0, tx}, 32'd0);
      tick(17);
      mon_en = 1'b0;
      exp_q.delete();
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_tx", {31'h0, tx}, 32'd1);
      check("midrst_busy", {31'h0, busy}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(2);
      check("midrst_busy_after", {31'h0, busy}, 32'd0);
      mon_en = 1'b1;
      st_valid = 1'b1;
      st_data = 32'h8001_7F40;
      push_word(32'h8001_7F40);
      tick(1);
      st_valid = 1'b0;
      wait_drain(WORD_CYC + 100);
      tick(5);
      check("final_busy", {31'h0, busy}, 32'd0);
      check("final_tx", {31'h0, tx}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/hd6309_trace_uart.md
# hd6309_trace_uart

Consumer end of the HD6309 bus-trace stream. Accepts 32-bit trace words from the bus-trace capture block on a valid-only interface with no backpressure. Buffers them in a small FIFO and serialises each word to the host as 8N1 UART bytes. Drops words when the buffer is full, and counts them so the host can detect gaps in the trace.

## Interface
Parameters:
- CLK_DIV, 434: clock cycles per UART bit; legal range 2..65535.
- FIFO_AW, 4: FIFO address width; depth = 2^FIFO_AW words.

Ports:
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- st_valid  input  1  one-cycle strobe; st_data is valid in that cycle.
- st_data  input  32  trace word {addr[15:0], data[7:0], rw, bs, 6'b0}.
- clr_ovf  input  1  one-cycle pulse; clears overflow and drop_count.
- tx  output  1  UART serial output; idle high.
- busy  output  1  high while the FIFO is non-empty or the transmitter is not in IDLE.
- overflow  output  1  sticky; set when any word is dropped.
- drop_count  output  8  saturating count of dropped words.

## Operation
- Reset values: tx=1, busy=0, overflow=0, drop_count=0, FIFO empty, FSM=IDLE.
- FIFO write: st_valid & ~full writes st_data.
- Drop: st_valid & full discards the word, sets overflow, and increments drop_count, which saturates at 255.
- Full with simultaneous pop: a pop in the same cycle as a write while full frees a slot, so the write is accepted. Full is evaluated after the pop.
- clr_ovf together with a drop: the drop wins, leaving overflow=1 and drop_count=1.
- Byte order per word: st_data[31:24], [23:16], [15:8], [7:0]. Each byte goes out LSB first.
- Frame: start bit (0), 8 data bits, stop bit (1).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop into a 32-bit shift holding register, set byte index to 0, and go to START. Otherwise hold tx=1.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=current bit for CLK_DIV cycles per bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. If bytes of the current word remain, go to START. Otherwise go to IDLE.
- Counters:
  - Bit timer counts 0..CLK_DIV-1.
  - Bit index is 3 bits.
  - Byte index is 2 bits, or 3 bits with sync enabled.
  - FIFO pointers are FIFO_AW+1 bits wide, so that full and empty can be distinguished on wrap-around.
- Reset asserted mid-frame: everything returns to reset values immediately and tx goes high. The partial frame and the FIFO contents are lost, and no counter is updated.

## Timing
- Latency from write to start bit, with an empty FIFO and an idle transmitter:
  - st_valid sampled at edge N.
  - FIFO non-empty after N.
  - IDLE pops at edge N+1.
  - tx falls at edge N+2.
- Bits within a word are contiguous: a stop bit is followed directly by the next start bit.
- Between words there is exactly one clk cycle of tx=1 in IDLE beyond the stop bit.
- Word duration is 40*CLK_DIV + 1 cycles, or 50*CLK_DIV + 1 with sync enabled.
- busy falls on the edge where the FSM enters IDLE with the FIFO empty.
- overflow and drop_count update one edge after the dropping st_valid.

## Configuration
- TRACE_UART_SYNC_EN defined: each word is preceded by a sync byte 0xA5, giving 5 bytes per word.
- TRACE_UART_SYNC_EN undefined: 4 bytes per word and no sync byte.
- The macro does not affect FIFO or overflow behaviour.

## Test plan
All scenarios use CLK_DIV=4 and FIFO_AW=2.
- Reset release, no stimulus -> tx stays 1, busy=0, drop_count=0 for 1000 cycles.
- Single st_valid with 32'h1234_5600 -> tx low 2 edges later; decoded bytes 12,34,56,00; busy low after 161 cycles; no sync byte unless enabled, in which case A5,12,34,56,00.
- 6 st_valid strobes on consecutive cycles, words W0..W5 -> first word popped immediately, 4 buffered, 1 dropped (W5); overflow=1, drop_count=1; transmitted W0..W4 in order, one idle cycle between words.
- Strobe when full in the same cycle as a pop -> word accepted, drop_count unchanged.
- 300 drops, then clr_ovf -> drop_count holds at 255, then clears to 0 and overflow=0; clr_ovf coincident with a drop -> drop_count=1, overflow=1.
- rst_n asserted during DATA bit 3 -> tx=1 immediately, FIFO empty, busy=0; after release, a new word transmits cleanly.
